// File: rtl/thermo_pkg.sv
// Shared thermostat constants, FSM state type and the raw-to-temperature clamp.
// Imported by the sensor front end and by the heating/cooling controller.
package thermo_pkg;
    localparam int TEMP_W       = 5;
    localparam int RAW_W        = 8;
    localparam int TEMP_MAX     = 31;
    localparam int SUM_W        = 7;
    localparam int SHIFT_CYCLES = 16;

    localparam logic [TEMP_W-1:0] DEADBAND_LO = 5'd18;
    localparam logic [TEMP_W-1:0] DEADBAND_HI = 5'd22;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_e;

    function automatic logic [TEMP_W-1:0] clamp_temp(input logic [RAW_W-1:0] raw);
        return (raw > RAW_W'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : raw[TEMP_W-1:0];
    endfunction
endpackage

// File: rtl/moving_avg4.sv
// 4-sample moving average with fill tracking; avg/full follow the registered history, 1 cycle after push.
// No backpressure: every push is accepted.
module moving_avg4
    import thermo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [TEMP_W-1:0] din,
    output logic [TEMP_W-1:0] avg,
    output logic              full
);
    localparam int         DEPTH    = 4;
    localparam logic [2:0] FILL_MAX = 3'd4;

    logic [DEPTH-1:0][TEMP_W-1:0] hist_q, hist_d;
    logic [2:0]                   fill_q, fill_d;
    logic [SUM_W-1:0]             sum;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (push) begin
            hist_d = {hist_q[DEPTH-2:0], din};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = sum + SUM_W'(hist_q[i]);
        end
    end

    // Divide by four by dropping the two LSBs: truncation, not rounding.
    assign avg  = sum[SUM_W-1:2];
    assign full = (fill_q == FILL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/temp_sensor_if.sv
// Periodic 3-wire sensor read, clamp and 4-sample average; temp_valid 19 cycles after conversion start.
// No backpressure: enable only gates new starts, a running conversion always completes.
module temp_sensor_if
    import thermo_pkg::*;
#(
    parameter int unsigned       SAMPLE_DIV = 1000,
    parameter logic [TEMP_W-1:0] RESET_TEMP = 5'd20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sensor_sdo,
    output logic              sensor_cs_n,
    output logic              sensor_sclk,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_valid,
    output logic              over_range
);
    localparam int               CNT_W      = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [3:0]       PHASE_LAST = 4'(SHIFT_CYCLES - 1);

    logic [CNT_W-1:0]  div_q, div_d;
    state_e            state_q, state_d;
    logic [3:0]        phase_q, phase_d;
    logic [RAW_W-1:0]  raw_q, raw_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              over_q, over_d;
    logic              upd_q;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic              vld_q, vld_d;

    logic              wrap, start, sample, push;
    logic [TEMP_W-1:0] clamped, avg;
    logic              full;

    // Start is taken on the wrap edge itself, so SETUP coincides with div_q == 0
    // and the all-zero counter straight out of reset never triggers a start.
    assign wrap  = (div_q == DIV_LAST);
    assign start = wrap && enable && (state_q == IDLE);
    assign div_d = wrap ? '0 : div_q + 1'b1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = SHIFT;
                phase_d = '0;
            end
            SHIFT: begin
                phase_d = phase_q + 4'd1;
                if (phase_q == PHASE_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus pins are registered from the next state so they line up with state_q.
    assign cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    assign sclk_d = (state_d == SHIFT) && !((state_q == SHIFT) && sclk_q);
    assign sample = sclk_d && !sclk_q;
    assign raw_d  = sample ? {raw_q[RAW_W-2:0], sensor_sdo} : raw_q;

    assign push    = (state_q == DONE);
    assign clamped = clamp_temp(raw_q);
    assign over_d  = push ? (raw_q > RAW_W'(TEMP_MAX)) : over_q;

    assign vld_d  = upd_q && full;
    assign temp_d = vld_d ? avg : temp_q;

    moving_avg4 u_avg (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (clamped),
        .avg  (avg),
        .full (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= IDLE;
            phase_q <= '0;
            raw_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            over_q  <= 1'b0;
            upd_q   <= 1'b0;
            temp_q  <= RESET_TEMP;
            vld_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            phase_q <= phase_d;
            raw_q   <= raw_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            over_q  <= over_d;
            upd_q   <= push;
            temp_q  <= temp_d;
            vld_q   <= vld_d;
        end
    end

    assign sensor_cs_n = cs_n_q;
    assign sensor_sclk = sclk_q;
    assign temperature = temp_q;
    assign temp_valid  = vld_q;
    assign over_range  = over_q;
endmodule

// File: tb/tb_temp_sensor_if.sv
// Bench for temp_sensor_if: sensor bus model, directed vector table, enable/reset corners, random words vs a queue model.
module tb_temp_sensor_if;
    localparam int DIV = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sensor_sdo;
    logic       sensor_cs_n;
    logic       sensor_sclk;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       over_range;

    int checks    = 0;
    int errors    = 0;
    int sclk_viol = 0;
    int hist[$];

    typedef struct {
        logic [7:0] w;
        logic [4:0] t;
        logic       v;
        logic       ov;
    } vec_t;

    vec_t tbl[15];

    temp_sensor_if #(
        .SAMPLE_DIV (DIV),
        .RESET_TEMP (5'd20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sensor_sdo  (sensor_sdo),
        .sensor_cs_n (sensor_cs_n),
        .sensor_sclk (sensor_sclk),
        .temperature (temperature),
        .temp_valid  (temp_valid),
        .over_range  (over_range)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sensor_cs_n && sensor_sclk) sclk_viol++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: keep the last four clamped readings; average only once four exist.
    task automatic model_push(input logic [7:0] w, output logic [4:0] t, output logic v);
        int s;
        hist.push_back((w > 8'd31) ? 31 : int'(w));
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
            s = 0;
            foreach (hist[i]) s += hist[i];
            t = 5'(s / 4);
            v = 1'b1;
        end else begin
            t = 5'd20;
            v = 1'b0;
        end
    endtask

    // Acts as the sensor for one conversion: bit 7 while CS is low, next bit after each SCLK fall.
    task automatic do_conv(input logic [7:0] w, input int budget, input int drop_at,
                           output int wc, output int lc, output int rises, output logic [7:0] raw,
                           output logic [4:0] t, output logic v, output logic ov,
                           output logic pulse_ok, output logic to);
        int   nf;
        logic prev;
        wc = 0; lc = 0; rises = 0; raw = '0; t = '0; v = 1'b0; ov = 1'b0;
        pulse_ok = 1'b0; to = 1'b0;
        while (sensor_cs_n && wc < budget) begin
            sensor_sdo = 1'($urandom);
            @(negedge clk);
            wc++;
        end
        if (sensor_cs_n) begin
            to = 1'b1;
            return;
        end
        nf   = 0;
        prev = sensor_sclk;
        while (!sensor_cs_n && lc < 40) begin
            if (prev && !sensor_sclk) nf++;
            if (!prev && sensor_sclk) rises++;
            prev = sensor_sclk;
            sensor_sdo = (nf < 8) ? w[3'(7 - nf)] : 1'($urandom);
            if (lc == drop_at) enable = 1'b0;
            @(negedge clk);
            lc++;
        end
        @(negedge clk);
        ov       = over_range;
        raw      = dut.raw_q;
        pulse_ok = !temp_valid;
        @(negedge clk);
        t = temperature;
        v = temp_valid;
        @(negedge clk);
        pulse_ok = pulse_ok && !temp_valid;
    endtask

    task automatic conv_check(input string nm, input logic [7:0] w, input logic [4:0] et,
                              input logic ev, input logic eov, input int budget,
                              input int drop_at, input int exp_wait);
        int         wc, lc, rs;
        logic [7:0] raw;
        logic [4:0] t;
        logic       v, ov, pok, to;
        do_conv(w, budget, drop_at, wc, lc, rs, raw, t, v, ov, pok, to);
        chk({nm, " timeout"}, int'(to), 0);
        if (to) return;
        if (exp_wait >= 0) chk({nm, " start_delay"}, wc, exp_wait);
        chk({nm, " cs_low_cycles"}, lc, 17);
        chk({nm, " sclk_rises"}, rs, 8);
        chk({nm, " raw"}, int'(raw), int'(w));
        chk({nm, " over_range"}, int'(ov), int'(eov));
        chk({nm, " temp_valid"}, int'(v), int'(ev));
        chk({nm, " temperature"}, int'(t), int'(et));
        chk({nm, " single_pulse"}, int'(pok), 1);
    endtask

    initial begin
        logic [4:0] mt;
        logic       mv;
        logic [7:0] w;
        int         falls;
        int         wc;

        tbl[0]  = '{8'd24,  5'd20, 1'b0, 1'b0};
        tbl[1]  = '{8'd24,  5'd20, 1'b0, 1'b0};
        tbl[2]  = '{8'd24,  5'd20, 1'b0, 1'b0};
        tbl[3]  = '{8'd24,  5'd24, 1'b1, 1'b0};
        tbl[4]  = '{8'd16,  5'd22, 1'b1, 1'b0};
        tbl[5]  = '{8'd17,  5'd20, 1'b1, 1'b0};
        tbl[6]  = '{8'd18,  5'd18, 1'b1, 1'b0};
        tbl[7]  = '{8'd21,  5'd18, 1'b1, 1'b0};
        tbl[8]  = '{8'd25,  5'd20, 1'b1, 1'b0};
        tbl[9]  = '{8'd200, 5'd23, 1'b1, 1'b1};
        tbl[10] = '{8'd200, 5'd27, 1'b1, 1'b1};
        tbl[11] = '{8'd200, 5'd29, 1'b1, 1'b1};
        tbl[12] = '{8'd200, 5'd31, 1'b1, 1'b1};
        tbl[13] = '{8'd10,  5'd25, 1'b1, 1'b0};
        tbl[14] = '{8'hA5,  5'd25, 1'b1, 1'b1};

        rst = 1'b1;
        enable = 1'b0;
        sensor_sdo = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset cs_n", int'(sensor_cs_n), 1);
        chk("reset sclk", int'(sensor_sclk), 0);
        chk("reset temperature", int'(temperature), 20);
        chk("reset temp_valid", int'(temp_valid), 0);
        chk("reset over_range", int'(over_range), 0);

        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            model_push(tbl[i].w, mt, mv);
            conv_check($sformatf("tbl%0d", i), tbl[i].w, tbl[i].t, tbl[i].v, tbl[i].ov,
                       3 * DIV, -1, (i == 0) ? DIV : -1);
        end

        // enable falls mid-SHIFT: conversion still completes, then no starts until re-enabled
        w = 8'd19;
        model_push(w, mt, mv);
        conv_check("en_drop", w, mt, mv, 1'b0, 3 * DIV, 6, -1);
        falls = 0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (!sensor_cs_n) falls++;
        end
        chk("en_off cs_low_cycles", falls, 0);
        enable = 1'b1;
        w = 8'd22;
        model_push(w, mt, mv);
        conv_check("en_resume", w, mt, mv, 1'b0, DIV + 1, -1, -1);

        // reset in the middle of SHIFT
        wc = 0;
        while (sensor_cs_n && wc < 3 * DIV) begin
            @(negedge clk);
            wc++;
        end
        chk("rst_mid conv_found", int'(sensor_cs_n), 0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid cs_n", int'(sensor_cs_n), 1);
        chk("rst_mid sclk", int'(sensor_sclk), 0);
        chk("rst_mid temperature", int'(temperature), 20);
        chk("rst_mid temp_valid", int'(temp_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            w = 8'(27 + i);
            model_push(w, mt, mv);
            conv_check($sformatf("post_rst%0d", i), w, mt, mv, 1'b0, 3 * DIV, -1,
                       (i == 0) ? DIV : -1);
        end

        for (int i = 0; i < 12; i++) begin
            w = (i % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            model_push(w, mt, mv);
            conv_check($sformatf("rand%0d", i), w, mt, mv, (w > 8'd31), 3 * DIV, -1, -1);
        end

        chk("sclk_high_while_cs_high", sclk_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
